// File: rtl/alarm_pkg.sv
`default_nettype none
//==============================================================
// Module  : alarm_pkg
// Brief   : shared state encodings, time limits and mode value
// Revision: 1.0
//==============================================================
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SET    = 2'd1,
        ST_RING   = 2'd2,
        ST_SNOOZE = 2'd3
    } state_e;

    localparam logic [7:0] HOUR_MAX = 8'd23;
    localparam logic [7:0] MIN_MAX  = 8'd59;
    localparam logic [1:0] MODE_SET = 2'd2;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alarm_setreg.sv
`default_nettype none
//==============================================================
// Module  : alarm_setreg
// Brief   : stored alarm hour/minute with independent wrap-around increment
// Revision: 1.0
//==============================================================
module alarm_setreg
    import alarm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc_hour_i,
    input  logic       inc_minute_i,
    output logic [7:0] hour_o,
    output logic [7:0] minute_o
);

    logic [7:0] hour_q, hour_d;
    logic [7:0] minute_q, minute_d;

    // Minute wrap deliberately does not carry into the hour field.
    always_comb begin
        hour_d   = hour_q;
        minute_d = minute_q;
        if (inc_hour_i) begin
            hour_d = (hour_q == HOUR_MAX) ? 8'd0 : hour_q + 8'd1;
        end
        if (inc_minute_i) begin
            minute_d = (minute_q == MIN_MAX) ? 8'd0 : minute_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hour_q   <= 8'd0;
            minute_q <= 8'd0;
        end else begin
            hour_q   <= hour_d;
            minute_q <= minute_d;
        end
    end

    assign hour_o   = hour_q;
    assign minute_o = minute_q;

endmodule
`default_nettype wire

// File: rtl/alarm_ctrl.sv
`default_nettype none
//==============================================================
// Module  : alarm_ctrl
// Brief   : alarm FSM with set mode, ring timeout and snooze countdown
// Revision: 1.0
//==============================================================
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic       turn,
    input  logic       change,
    input  logic       sec_tick,
    input  logic [7:0] cur_hour,
    input  logic [7:0] cur_minute,
    input  logic [7:0] cur_second,
    input  logic       alarm_en,
    input  logic       stop,
    input  logic       snooze,
    output logic [7:0] alarm_hour,
    output logic [7:0] alarm_minute,
    output logic       ring,
    output logic [1:0] state
);

    localparam int              CNT_W       = $clog2(imax(RING_SECS, SNOOZE_SECS) + 1);
    localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_SECS - 1);
    localparam logic [CNT_W-1:0] SNOOZE_LOAD = CNT_W'(SNOOZE_SECS);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ring_q, ring_d;
    logic              change_q;
    logic              change_edge;
    logic              trigger;

    assign change_edge = change & ~change_q;
    assign trigger     = alarm_en && sec_tick && (cur_hour == alarm_hour)
                      && (cur_minute == alarm_minute) && (cur_second == 8'd0);

    alarm_setreg u_setreg (
        .clk          (clk),
        .rst_n        (rst_n),
        .inc_hour_i   ((state_q == ST_SET) && change_edge && turn),
        .inc_minute_i ((state_q == ST_SET) && change_edge && !turn),
        .hour_o       (alarm_hour),
        .minute_o     (alarm_minute)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (mode == MODE_SET) begin
            state_d = ST_SET;
        end else begin
            unique case (state_q)
                ST_SET: state_d = ST_IDLE;
                ST_IDLE: begin
                    if (trigger) begin
                        state_d = ST_RING;
                        cnt_d   = '0;
                    end
                end
                ST_RING: begin
                    if (!alarm_en || stop) begin
                        state_d = ST_IDLE;
                    end else if (snooze) begin
                        state_d = ST_SNOOZE;
                        cnt_d   = SNOOZE_LOAD;
                    end else if (sec_tick) begin
                        if (cnt_q >= RING_LAST) begin
                            state_d = ST_IDLE;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end
                ST_SNOOZE: begin
                    // Snooze pulses are ignored here; only stop, disarm or expiry leave.
                    if (!alarm_en || stop) begin
                        state_d = ST_IDLE;
                    end else if (sec_tick) begin
                        if (cnt_q <= CNT_ONE) begin
                            state_d = ST_RING;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        ring_d = (state_d == ST_RING);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            ring_q   <= 1'b0;
            change_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ring_q   <= ring_d;
            change_q <= change;
        end
    end

    assign ring  = ring_q;
    assign state = state_q;

endmodule
`default_nettype wire

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 SHALL have parameter RING_SECS, default 60, sec_tick count before an unanswered ring auto-stops.
REQ-002 SHALL have parameter SNOOZE_SECS, default 300, sec_tick count of one snooze interval.
REQ-003 SHALL have port clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port mode  in  2  clock mode; 2 = alarm-set mode, other values = run.
REQ-006 SHALL have port turn  in  1  field select in set mode; 1 = hour, 0 = minute.
REQ-007 SHALL have port change  in  1  synchronous increment request; acts on its rising edge.
REQ-008 SHALL have port sec_tick  in  1  one-cycle strobe, once per second.
REQ-009 SHALL have ports cur_hour / cur_minute / cur_second  in  8 each  current time, binary 0-23 / 0-59 / 0-59.
REQ-010 SHALL have port alarm_en  in  1  alarm armed when 1.
REQ-011 SHALL have ports stop / snooze  in  1 each  user one-cycle pulses.
REQ-012 SHALL have ports alarm_hour / alarm_minute  out  8 each  stored alarm time, binary.
REQ-013 SHALL have port ring  out  1  buzzer drive, registered.
REQ-014 SHALL have port state  out  2  current FSM state encoding.

Function
REQ-015 SHALL implement FSM states IDLE=0, SET=1, RING=2, SNOOZE=3.
REQ-016 SHALL detect change edges by registering change; an edge is change=1 with the previous-cycle sample 0.
REQ-017 SHALL, in SET on a change edge with turn=1, set alarm_hour to 0 if it was 23, else alarm_hour+1, visible the next cycle.
REQ-018 SHALL, in SET on a change edge with turn=0, set alarm_minute to 0 if it was 59, else alarm_minute+1, with no carry into alarm_hour.
REQ-019 SHALL ignore change edges outside SET; alarm_hour/alarm_minute hold their value.
REQ-020 SHALL enter SET from any state on the cycle mode==2, with priority over all other events; this cancels ring and any snooze.
REQ-021 SHALL go from SET to IDLE on the first cycle mode!=2.
REQ-022 SHALL go from IDLE to RING when alarm_en=1, sec_tick=1, cur_hour==alarm_hour, cur_minute==alarm_minute and cur_second==0; ring=1 from the next cycle.
REQ-023 SHALL, in RING, hold ring=1 and count sec_ticks; after RING_SECS ticks, go to IDLE with ring=0.
REQ-024 SHALL, in RING, on a stop pulse go to IDLE with ring=0 the next cycle.
REQ-025 SHALL, in RING, on a snooze pulse go to SNOOZE with ring=0 and the counter loaded with SNOOZE_SECS.
REQ-026 SHALL, in SNOOZE, decrement on each sec_tick and go to RING (ring timer restarted at 0) when the count reaches 0.
REQ-027 SHALL, in SNOOZE, go to IDLE on stop; further snooze pulses are ignored.
REQ-028 SHALL give stop priority over snooze when both arrive in the same cycle.
REQ-029 SHALL send RING or SNOOZE to IDLE with ring=0 on any cycle alarm_en=0.
REQ-030 SHALL not retrigger in IDLE within the same matched minute after stop or timeout, because the trigger requires cur_second==0.
REQ-031 SHALL size the counter to hold max(RING_SECS, SNOOZE_SECS).

Reset
REQ-032 SHALL, while rst_n=0, force state=IDLE, ring=0, alarm_hour=0, alarm_minute=0, counter=0 and the change history to 0, independent of clk.
REQ-033 SHALL abandon any RING or SNOOZE on reset assertion mid-operation, with no pending ring after release.

Structure
REQ-034 SHALL place the state encodings, hour/minute limits (23, 59) and the mode value 2 in shared package alarm_pkg.
REQ-035 SHALL put the wrap-around hour/minute incrementer in a sub-module alarm_setreg; the FSM and counter stay in alarm_ctrl.

Verification
REQ-036 SHALL verify: mode=2, turn=1, alarm_hour=23, change edge -> alarm_hour=0 and alarm_minute unchanged; turn=0 at 59 -> alarm_minute=0.
REQ-037 SHALL verify: alarm 07:30, alarm_en=1, time 07:30:00 with sec_tick -> ring=1 next cycle and state=RING.
REQ-038 SHALL verify: RING with no input, RING_SECS=4 -> ring falls after the 4th sec_tick, state=IDLE, no retrigger at 07:30:05.
REQ-039 SHALL verify: RING, snooze pulse, SNOOZE_SECS=3 -> ring=0, then ring=1 after the 3rd sec_tick.
REQ-040 SHALL verify: stop and snooze in the same cycle during RING -> IDLE; mode=2 during SNOOZE -> SET with ring=0.
REQ-041 SHALL verify: rst_n low mid-RING, asynchronous to clk -> ring=0, state=IDLE and alarm time 00:00 immediately.
